acp_mm2s_engine: RTL and testbench

//  Executes the 72-bit host-to-stream command issued by axi4_stream_master.
//  For each command it reads memory over AXI4 bursts on the ACP port and

---
 rtl/acp_mm2s_engine_if.sv | 63 ++++++
 rtl/acp_mm2s_engine.sv | 165 ++++++++++++++++
 tb/tb_acp_mm2s_engine.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acp_mm2s_engine_if.sv
// Bus bundle for acp_mm2s_engine: command/status streams, ACP read channels and the data stream.
// "master" is the engine's view; "slave" is the surrounding system's view.
interface acp_mm2s_engine_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [71:0]     S_AXIS_CMD_TDATA;
  logic            S_AXIS_CMD_TVALID;
  logic            S_AXIS_CMD_TREADY;

  logic [7:0]      M_AXIS_STS_TDATA;
  logic            M_AXIS_STS_TVALID;
  logic            M_AXIS_STS_TREADY;

  logic [AW-1:0]   M_AXI_ARADDR;
  logic [7:0]      M_AXI_ARLEN;
  logic [2:0]      M_AXI_ARSIZE;
  logic [1:0]      M_AXI_ARBURST;
  logic [2:0]      M_AXI_ARPROT;
  logic [3:0]      M_AXI_ARCACHE;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;

  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RLAST;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  logic [DW-1:0]   M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TKEEP;
  logic            M_AXIS_TLAST;
  logic            M_AXIS_TVALID;
  logic            M_AXIS_TREADY;

  modport master (
    input  S_AXIS_CMD_TDATA, S_AXIS_CMD_TVALID,
    output S_AXIS_CMD_TREADY,
    output M_AXIS_STS_TDATA, M_AXIS_STS_TVALID,
    input  M_AXIS_STS_TREADY,
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARPROT, M_AXI_ARCACHE, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY,
    output M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
    input  M_AXIS_TREADY
  );

  modport slave (
    output S_AXIS_CMD_TDATA, S_AXIS_CMD_TVALID,
    input  S_AXIS_CMD_TREADY,
    input  M_AXIS_STS_TDATA, M_AXIS_STS_TVALID,
    output M_AXIS_STS_TREADY,
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARPROT, M_AXI_ARCACHE, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY,
    input  M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TVALID,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/acp_mm2s_engine.sv
// MM2S command executor: splits each command into 4KB-safe ACP read bursts (one outstanding),
// passes R data straight through to the stream with zero latency, then returns one status byte.
module acp_mm2s_engine #(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 64,
  parameter int         C_MAX_BURST        = 16,
  parameter logic [2:0] C_PROT             = 3'b010,
  parameter logic [3:0] C_CACHE            = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  acp_mm2s_engine_if.master  bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [19:0] MAX_BEATS = 20'(C_MAX_BURST);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_STATUS = 2'd3;

  logic [1:0]    state_q,  state_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q,  arlen_d;
  logic [19:0]   rem_q,    rem_d;
  logic [3:0]    tag_q,    tag_d;
  logic          eof_q,    eof_d;
  logic          interr_q, interr_d;
  logic          slverr_q, slverr_d;
  logic          decerr_q, decerr_d;

  logic [22:0]   cmd_btt;
  logic [AW-1:0] cmd_saddr;
  logic          cmd_bad;
  logic [8:0]    first_beats;
  logic [8:0]    next_beats;
  logic [8:0]    cur_beats;
  logic          beat_hs;
  logic          err_seen;
  logic          unused_cmd_bits;

  // Beats for the next burst: limited by what is left, the burst cap and the next 4KB page edge.
  function automatic logic [8:0] burst_beats(input logic [AW-1:0] addr, input logic [19:0] rem);
    logic [9:0]  to_page;
    logic [19:0] n;
    to_page = 10'd512 - {1'b0, addr[11:3]};
    n = rem;
    if (n > MAX_BEATS)           n = MAX_BEATS;
    if (n > {10'd0, to_page})    n = {10'd0, to_page};
    return n[8:0];
  endfunction

  assign cmd_btt     = bus.S_AXIS_CMD_TDATA[22:0];
  assign cmd_saddr   = AW'(bus.S_AXIS_CMD_TDATA[63:32]);
  assign cmd_bad     = (cmd_btt == 23'd0) || (cmd_saddr[2:0] != 3'd0) || (cmd_btt[2:0] != 3'd0);
  assign first_beats = burst_beats(cmd_saddr, cmd_btt[22:3]);
  assign next_beats  = burst_beats(araddr_q, rem_q);
  assign cur_beats   = {1'b0, arlen_q} + 9'd1;

  assign beat_hs  = (state_q == S_DATA) && bus.M_AXI_RVALID && bus.M_AXIS_TREADY;
  // The error on the beat being presented counts, so a failing last beat still ends the command.
  assign err_seen = slverr_q || decerr_q || (bus.M_AXI_RVALID && bus.M_AXI_RRESP[1]);

  assign unused_cmd_bits = &{1'b0, bus.S_AXIS_CMD_TDATA[71:68], bus.S_AXIS_CMD_TDATA[31],
                             bus.S_AXIS_CMD_TDATA[29:23]};

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    rem_d    = rem_q;
    tag_d    = tag_q;
    eof_d    = eof_q;
    interr_d = interr_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.S_AXIS_CMD_TVALID) begin
          tag_d    = bus.S_AXIS_CMD_TDATA[67:64];
          eof_d    = bus.S_AXIS_CMD_TDATA[30];
          rem_d    = cmd_btt[22:3];
          araddr_d = cmd_saddr;
          arlen_d  = 8'(first_beats - 9'd1);
          interr_d = cmd_bad;
          slverr_d = 1'b0;
          decerr_d = 1'b0;
          state_d  = cmd_bad ? S_STATUS : S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.M_AXI_ARREADY) begin
          araddr_d = araddr_q + AW'({cur_beats, 3'b000});
          rem_d    = rem_q - {11'd0, cur_beats};
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (beat_hs) begin
          if (bus.M_AXI_RRESP == 2'b10) slverr_d = 1'b1;
          if (bus.M_AXI_RRESP == 2'b11) decerr_d = 1'b1;
          if (bus.M_AXI_RLAST) begin
            if ((rem_q == 20'd0) || err_seen) begin
              state_d = S_STATUS;
            end else begin
              arlen_d = 8'(next_beats - 9'd1);
              state_d = S_ADDR;
            end
          end
        end
      end
      S_STATUS: begin
        if (bus.M_AXIS_STS_TREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      rem_q    <= '0;
      tag_q    <= '0;
      eof_q    <= 1'b0;
      interr_q <= 1'b0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      rem_q    <= rem_d;
      tag_q    <= tag_d;
      eof_q    <= eof_d;
      interr_q <= interr_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
    end
  end

  // Ready is masked by rst so nothing is advertised while reset is held.
  assign bus.S_AXIS_CMD_TREADY = (state_q == S_IDLE) && !rst;

  assign bus.M_AXIS_STS_TVALID = (state_q == S_STATUS);
  assign bus.M_AXIS_STS_TDATA  = (state_q == S_STATUS) ?
      {!(interr_q || slverr_q || decerr_q), slverr_q, decerr_q, interr_q, tag_q} : 8'h00;

  assign bus.M_AXI_ARVALID = (state_q == S_ADDR);
  assign bus.M_AXI_ARADDR  = araddr_q;
  assign bus.M_AXI_ARLEN   = arlen_q;
  assign bus.M_AXI_ARSIZE  = 3'b011;
  assign bus.M_AXI_ARBURST = 2'b01;
  assign bus.M_AXI_ARPROT  = C_PROT;
  assign bus.M_AXI_ARCACHE = C_CACHE;

  assign bus.M_AXI_RREADY  = (state_q == S_DATA) && bus.M_AXIS_TREADY;
  assign bus.M_AXIS_TVALID = (state_q == S_DATA) && bus.M_AXI_RVALID;
  assign bus.M_AXIS_TDATA  = (state_q == S_DATA) ? bus.M_AXI_RDATA : {DW{1'b0}};
  assign bus.M_AXIS_TKEEP  = {(DW/8){1'b1}};
  assign bus.M_AXIS_TLAST  = (state_q == S_DATA) && bus.M_AXI_RVALID && bus.M_AXI_RLAST &&
                             eof_q && ((rem_q == 20'd0) || err_seen);
endmodule

// File: tb/tb_acp_mm2s_engine.sv
// Bench for acp_mm2s_engine: command-level model predicts AR bursts, stream beats and status bytes,
// a memory slave answers the ACP reads, and one negedge process checks the outputs.
`timescale 1ns/1ps
module tb_acp_mm2s_engine;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acp_mm2s_engine_if bus();
  acp_mm2s_engine dut (.clk(clk), .rst(rst), .bus(bus));

  ar_t         exp_ar[$];
  beat_t       exp_beat[$];
  logic [7:0]  exp_sts[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          beat_cnt = 0;
  bit          stall_en = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [1:0]  err_resp = 2'b10;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_5A5A, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Whole-command model: walk the transfer in page/cap-limited bursts, stop after an erroring burst.
  task automatic model_cmd(input logic [31:0] saddr, input logic [22:0] btt, input bit eof,
                           input logic [3:0] tag);
    int unsigned a, rem, len, room;
    bit slv, dec, err;
    ar_t r;
    beat_t b;
    if (btt == 0 || saddr % 8 != 0 || btt % 8 != 0) begin
      exp_sts.push_back({4'b0001, tag});
      return;
    end
    a = saddr; rem = int'(btt) / 8; slv = 0; dec = 0; err = 0;
    while (rem > 0 && !err) begin
      room = (4096 - (a % 4096)) / 8;
      len = rem;
      if (len > 16) len = 16;
      if (len > room) len = room;
      r.addr = a; r.len = 8'(len - 1);
      exp_ar.push_back(r);
      for (int unsigned j = 0; j < len; j++) begin
        b.data = mem_word(32'(a + 8 * j));
        b.last = 1'b0;
        exp_beat.push_back(b);
        if (32'(a + 8 * j) == err_addr) begin
          err = 1;
          if (err_resp == 2'b11) dec = 1; else slv = 1;
        end
      end
      a = a + 8 * len;
      rem = rem - len;
    end
    if (eof) exp_beat[exp_beat.size() - 1].last = 1'b1;
    exp_sts.push_back({~(slv | dec), slv, dec, 1'b0, tag});
  endtask

  task automatic issue_cmd(input logic [31:0] saddr, input logic [22:0] btt, input bit eof,
                           input logic [3:0] tag);
    int n = 0;
    @(posedge clk); #1;
    bus.S_AXIS_CMD_TDATA  = {4'h0, tag, saddr, 1'b0, eof, 7'd0, btt};
    bus.S_AXIS_CMD_TVALID = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.S_AXIS_CMD_TREADY) break;
      n++;
      if (n > 3000) begin fail_now("cmd_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    bus.S_AXIS_CMD_TVALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_sts.size() != 0 || exp_beat.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("cmd_done_timeout");
    chk("drain_sts_beats", 64'(exp_sts.size() + exp_beat.size()), 64'd0);
    chk("drain_ar", 64'(exp_ar.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Back-pressure generator for the stream and status sinks.
  always @(posedge clk) begin
    #1;
    bus.M_AXIS_TREADY     = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.M_AXIS_STS_TREADY = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Memory slave on the ACP read port.
  initial begin : slave_proc
    ar_t r;
    int d, n, blen;
    bit aborted;
    logic [31:0] ba;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RLAST   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.M_AXI_ARVALID) begin
        r.addr = bus.M_AXI_ARADDR;
        r.len  = bus.M_AXI_ARLEN;
        d = stall_en ? $urandom_range(0, 3) : 0;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          chk("ar_stable", {23'd0, bus.M_AXI_ARVALID, bus.M_AXI_ARLEN, bus.M_AXI_ARADDR},
              {23'd0, 1'b1, r.len, r.addr});
        end
        @(posedge clk); #1;
        bus.M_AXI_ARREADY = 1'b1;
        @(negedge clk);
        ba   = bus.M_AXI_ARADDR;
        blen = int'(bus.M_AXI_ARLEN);
        if (exp_ar.size() == 0) begin
          fail_now("unexpected_ar");
        end else begin
          r = exp_ar.pop_front();
          chk("araddr", 64'(bus.M_AXI_ARADDR), 64'(r.addr));
          chk("arlen", 64'(bus.M_AXI_ARLEN), 64'(r.len));
          chk("ar_fixed", 64'({bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST, bus.M_AXI_ARPROT, bus.M_AXI_ARCACHE}),
              64'({3'b011, 2'b01, 3'b010, 4'b1111}));
        end
        @(posedge clk); #1;
        bus.M_AXI_ARREADY = 1'b0;
        aborted = 1'b0;
        for (int j = 0; j <= blen; j++) begin
          if (stall_en) begin
            d = $urandom_range(0, 2);
            repeat (d) begin @(posedge clk); #1; end
          end
          bus.M_AXI_RVALID = 1'b1;
          bus.M_AXI_RDATA  = mem_word(32'(ba + 32'(8 * j)));
          bus.M_AXI_RRESP  = (32'(ba + 32'(8 * j)) == err_addr) ? err_resp : 2'b00;
          bus.M_AXI_RLAST  = (j == blen);
          n = 0;
          forever begin
            @(negedge clk);
            if (rst) begin aborted = 1'b1; break; end
            if (bus.M_AXI_RREADY) break;
            n++;
            if (n > 1000) begin fail_now("rready_timeout"); aborted = 1'b1; break; end
          end
          if (aborted) break;
          @(posedge clk); #1;
          bus.M_AXI_RVALID = 1'b0;
          bus.M_AXI_RLAST  = 1'b0;
        end
        if (aborted) begin
          bus.M_AXI_RVALID = 1'b0;
          bus.M_AXI_RLAST  = 1'b0;
        end
      end
    end
  end

  // Single compare point for stream and status outputs.
  always @(negedge clk) begin
    beat_t b;
    logic [7:0] s;
    if (!rst) begin
      if (bus.M_AXI_RVALID || bus.M_AXIS_TVALID) begin
        chk("tvalid_follows_rvalid", 64'(bus.M_AXIS_TVALID), 64'(bus.M_AXI_RVALID));
        chk("rready_mirrors_tready", 64'(bus.M_AXI_RREADY), 64'(bus.M_AXIS_TREADY));
      end
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        if (exp_beat.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          b = exp_beat.pop_front();
          chk("tdata", bus.M_AXIS_TDATA, b.data);
          chk("tlast", 64'(bus.M_AXIS_TLAST), 64'(b.last));
          chk("tkeep", 64'(bus.M_AXIS_TKEEP), 64'hff);
          beat_cnt++;
        end
      end
      if (bus.M_AXIS_STS_TVALID) begin
        chk("cmd_ready_low_in_status", 64'(bus.S_AXIS_CMD_TREADY), 64'd0);
        if (bus.M_AXIS_STS_TREADY) begin
          if (exp_sts.size() == 0) begin
            fail_now("unexpected_status");
          end else begin
            s = exp_sts.pop_front();
            chk("sts_tdata", 64'(bus.M_AXIS_STS_TDATA), 64'(s));
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, 64'(bus.M_AXI_ARVALID), 64'd0);
    chk({tag, "_rready"}, 64'(bus.M_AXI_RREADY), 64'd0);
    chk({tag, "_tvalid"}, 64'({bus.M_AXIS_TVALID, bus.M_AXIS_TLAST}), 64'd0);
    chk({tag, "_tdata"}, bus.M_AXIS_TDATA, 64'd0);
    chk({tag, "_sts"}, 64'({bus.M_AXIS_STS_TVALID, bus.M_AXIS_STS_TDATA}), 64'd0);
    chk({tag, "_cmd_tready"}, 64'(bus.S_AXIS_CMD_TREADY), 64'd0);
    chk({tag, "_ar_regs"}, 64'({bus.M_AXI_ARLEN, bus.M_AXI_ARADDR}), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin : main
    int n;
    int start;
    bus.S_AXIS_CMD_TVALID = 1'b0;
    bus.S_AXIS_CMD_TDATA  = '0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_tready", 64'(bus.S_AXIS_CMD_TREADY), 64'd1);

    // 1: single aligned burst
    model_cmd(32'h1000, 23'd64, 1'b1, 4'd3);
    chk("pin1_ar", 64'({exp_ar[0].addr, exp_ar[0].len}), 64'({32'h1000, 8'd7}));
    chk("pin1_nbeats", 64'(exp_beat.size()), 64'd8);
    chk("pin1_last", 64'(exp_beat[7].last), 64'd1);
    chk("pin1_sts", 64'(exp_sts[0]), 64'h83);
    issue_cmd(32'h1000, 23'd64, 1'b1, 4'd3);
    wait_done();

    // 2: split at the 4KB boundary
    model_cmd(32'h0FF0, 23'd48, 1'b1, 4'd4);
    chk("pin2_nar", 64'(exp_ar.size()), 64'd2);
    chk("pin2_ar0", 64'({exp_ar[0].addr, exp_ar[0].len}), 64'({32'h0FF0, 8'd1}));
    chk("pin2_ar1", 64'({exp_ar[1].addr, exp_ar[1].len}), 64'({32'h1000, 8'd3}));
    issue_cmd(32'h0FF0, 23'd48, 1'b1, 4'd4);
    wait_done();

    // 3: malformed commands produce INTERR and no bus traffic
    model_cmd(32'h2000, 23'd12, 1'b1, 4'd5);
    chk("pin3_sts", 64'(exp_sts[0]), 64'h15);
    issue_cmd(32'h2000, 23'd12, 1'b1, 4'd5);
    wait_done();
    model_cmd(32'h1004, 23'd64, 1'b1, 4'd5);
    issue_cmd(32'h1004, 23'd64, 1'b1, 4'd5);
    wait_done();
    model_cmd(32'h3000, 23'd0, 1'b1, 4'd6);
    issue_cmd(32'h3000, 23'd0, 1'b1, 4'd6);
    wait_done();

    // 4: SLVERR on beat 3 of the first burst
    err_addr = 32'h1010; err_resp = 2'b10;
    model_cmd(32'h1000, 23'd256, 1'b1, 4'd9);
    chk("pin4_nar", 64'(exp_ar.size()), 64'd1);
    chk("pin4_nbeats", 64'(exp_beat.size()), 64'd16);
    chk("pin4_sts", 64'(exp_sts[0]), 64'h49);
    issue_cmd(32'h1000, 23'd256, 1'b1, 4'd9);
    wait_done();
    err_addr = 32'h5008; err_resp = 2'b11;
    model_cmd(32'h5000, 23'd256, 1'b0, 4'd2);
    chk("pin4b_sts", 64'(exp_sts[0]), 64'h22);
    issue_cmd(32'h5000, 23'd256, 1'b0, 4'd2);
    wait_done();
    err_addr = 32'hFFFF_FFFF;

    // 5: random stalls, back-to-back commands queued while busy
    stall_en = 1'b1;
    model_cmd(32'h3F80, 23'd200, 1'b1, 4'd7);
    issue_cmd(32'h3F80, 23'd200, 1'b1, 4'd7);
    model_cmd(32'h7FF8, 23'd72, 1'b0, 4'd1);
    issue_cmd(32'h7FF8, 23'd72, 1'b0, 4'd1);
    model_cmd(32'h0100, 23'd20, 1'b1, 4'hA);
    issue_cmd(32'h0100, 23'd20, 1'b1, 4'hA);
    model_cmd(32'h0E00, 23'd1024, 1'b1, 4'hB);
    issue_cmd(32'h0E00, 23'd1024, 1'b1, 4'hB);
    wait_done();
    stall_en = 1'b0;
    repeat (3) @(negedge clk);

    // 6: reset in the middle of a data burst, then a clean command
    model_cmd(32'h2000, 23'd256, 1'b1, 4'd8);
    start = beat_cnt;
    issue_cmd(32'h2000, 23'd256, 1'b1, 4'd8);
    n = 0;
    while (beat_cnt < start + 5 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) fail_now("reset_test_no_beats");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_all_zero("midburst_reset");
    exp_ar.delete();
    exp_beat.delete();
    exp_sts.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_tready", 64'(bus.S_AXIS_CMD_TREADY), 64'd1);
    model_cmd(32'h3000, 23'd32, 1'b1, 4'hC);
    chk("pin6_sts", 64'(exp_sts[0]), 64'h8C);
    issue_cmd(32'h3000, 23'd32, 1'b1, 4'hC);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
